mcdt_arbiter: RTL



---
 rtl/mcdt_arb_pkg.sv | 12 +
 rtl/mcdt_rr_picker.sv | 39 +++
 rtl/mcdt_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mcdt_arb_pkg.sv
// Shared types and default sizes for the mcdt output scheduler.
package mcdt_arb_pkg;

  localparam int DEF_NCH  = 3;
  localparam int DEF_DW   = 32;
  localparam int DEF_LENW = 3;

  typedef enum logic {IDLE, SEND} state_t;

  typedef logic [1:0] prio_t;

endpackage

// File: rtl/mcdt_rr_picker.sv
// Combinational selector: lowest priority value wins, ties broken round-robin
// starting at the channel after ptr_i.
module mcdt_rr_picker
  import mcdt_arb_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]   elig_i,
  input  logic [2*NCH-1:0] prio_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic             found_o,
  output logic [IDW-1:0]   gnt_o
);

  prio_t min_p;
  logic  hit;
  int    idx;

  // Best priority among eligible channels, then first match in rotated order.
  always_comb begin
    min_p   = 2'd3;
    hit     = 1'b0;
    idx     = 0;
    gnt_o   = '0;
    found_o = |elig_i;
    for (int i = 0; i < NCH; i++) begin
      if (elig_i[i] && (prio_i[2*i +: 2] < min_p)) min_p = prio_i[2*i +: 2];
    end
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(ptr_i) + k) % NCH;
      if (!hit && elig_i[idx] && (prio_i[2*idx +: 2] == min_p)) begin
        hit   = 1'b1;
        gnt_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mcdt_arbiter.sv
// Output-side scheduler: grants one channel FIFO at a time for a burst of
// len+1 words, pops it, and feeds a back-pressurable output register.
module mcdt_arbiter
  import mcdt_arb_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int DW   = DEF_DW,
  parameter int LENW = DEF_LENW,
  parameter int IDW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH-1:0]    ch_en_i,
  input  logic [2*NCH-1:0]  ch_prio_i,
  input  logic [LENW*NCH-1:0] ch_len_i,
  input  logic [NCH-1:0]    ch_req_i,
  input  logic [DW*NCH-1:0] ch_data_i,
  output logic [NCH-1:0]    ch_ack_o,
  input  logic              out_rdy_i,
  output logic [DW-1:0]     mcdt_data_o,
  output logic              mcdt_val_o,
  output logic [IDW-1:0]    mcdt_id_o,
  output logic              busy_o
);

  localparam logic [IDW-1:0]  PTR_RST = IDW'(NCH - 1);
  localparam logic [LENW-1:0] CNT_ONE = LENW'(1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            val_q, val_d;
  logic [IDW-1:0]  id_q, id_d;

  logic [NCH-1:0]  elig;
  logic            slot;
  logic            found;
  logic [IDW-1:0]  pick;

  assign elig = ch_en_i & ch_req_i;
  assign slot = !val_q || out_rdy_i;

  mcdt_rr_picker #(.NCH(NCH), .IDW(IDW)) u_picker (
    .elig_i  (elig),
    .prio_i  (ch_prio_i),
    .ptr_i   (ptr_q),
    .found_o (found),
    .gnt_o   (pick)
  );

  // Next-state: arbitration in IDLE, word transfer / early end in SEND,
  // output register drains whenever downstream takes the word.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    val_d    = val_q;
    id_d     = id_q;
    ch_ack_o = '0;
    if (val_q && out_rdy_i) val_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          len_d   = ch_len_i[int'(pick)*LENW +: LENW];
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (slot) begin
          if (elig[gnt_q]) begin
            ch_ack_o[gnt_q] = 1'b1;
            data_d = ch_data_i[int'(gnt_q)*DW +: DW];
            id_d   = gnt_q;
            val_d  = 1'b1;
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == len_q) begin
              state_d = IDLE;
              ptr_d   = gnt_q;
            end
          end else begin
            // FIFO ran dry or channel got disabled: cut the burst short.
            state_d = IDLE;
            ptr_d   = gnt_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset also drops any word still held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
      data_q  <= '0;
      val_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      val_q   <= val_d;
      id_q    <= id_d;
    end
  end

  assign mcdt_data_o = data_q;
  assign mcdt_val_o  = val_q;
  assign mcdt_id_o   = id_q;
  assign busy_o      = (state_q == SEND);

endmodule
